// File: rtl/aha_reset_sequencer_if.sv
// Interface: aha_reset_sequencer_if
// Groups the software-facing control signals and the per-domain REQ/ACK
// handshake of the reset sequencer. The slave modport is the sequencer and
// the master modport is its environment: register block plus reset generators.
// The abort signal exists only when AHA_RESET_SEQ_ABORT_EN is defined.
interface aha_reset_sequencer_if #(
  parameter int NUM_DOMAINS = 8
) ();
  logic                   start;
  logic [NUM_DOMAINS-1:0] mask;
  logic                   busy;
  logic                   done;
  logic                   timeout_err;
  logic [4:0]             err_domain;
  logic [NUM_DOMAINS-1:0] rst_req;
  logic [NUM_DOMAINS-1:0] rst_ack;
`ifdef AHA_RESET_SEQ_ABORT_EN
  logic                   abort;

  modport slave (
    input  start, mask, rst_ack, abort,
    output busy, done, timeout_err, err_domain, rst_req
  );

  modport master (
    output start, mask, rst_ack, abort,
    input  busy, done, timeout_err, err_domain, rst_req
  );
`else
  modport slave (
    input  start, mask, rst_ack,
    output busy, done, timeout_err, err_domain, rst_req
  );

  modport master (
    output start, mask, rst_ack,
    input  busy, done, timeout_err, err_domain, rst_req
  );
`endif
endinterface

// File: rtl/aha_reset_sequencer.sv
// Module: aha_reset_sequencer
// Walks a captured domain mask in ascending index order and runs a 4-phase
// REQ/ACK handshake with each selected reset generator. Each handshake phase
// has a timeout; a timed-out domain is abandoned and the walk continues.
// Optional feature macro: AHA_RESET_SEQ_ABORT_EN adds an abort input that
// empties the remaining mask; the domain in flight still finishes its handshake.
module aha_reset_sequencer #(
  parameter int NUM_DOMAINS    = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GAP_CYCLES     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  aha_reset_sequencer_if.slave    bus
);

  localparam int CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_LAST);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    REQ_HI,
    ACK_LO,
    GAP,
    FINISH
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_DOMAINS-1:0] rem_q, rem_d;
  logic [NUM_DOMAINS-1:0] sel_q, sel_d;
  logic [NUM_DOMAINS-1:0] req_q, req_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   err_q, err_d;
  logic [4:0]             err_dom_q, err_dom_d;
  logic                   aborted_q, aborted_d;

  logic [NUM_DOMAINS-1:0] ack_meta, ack_sync;
  logic [NUM_DOMAINS-1:0] lowest;
  logic [4:0]             cur_idx;
  logic [CNT_W-1:0]       cnt_sat;
  logic                   ack_cur;
  logic                   cnt_expired;
  logic                   abort_in;

`ifdef AHA_RESET_SEQ_ABORT_EN
  assign abort_in = bus.abort;
`else
  assign abort_in = 1'b0;
`endif

  // Two-flop synchroniser for the asynchronous generator acknowledges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_meta <= '0;
      ack_sync <= '0;
    end else begin
      ack_meta <= bus.rst_ack;
      ack_sync <= ack_meta;
    end
  end

  // Isolate the lowest pending domain so the walk runs in ascending order
  always_comb begin
    lowest = '0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      if (rem_q[i]) begin
        lowest    = '0;
        lowest[i] = 1'b1;
      end
    end
  end

  // Binary index of the domain in flight, reported on the first timeout
  always_comb begin
    cur_idx = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (sel_q[i]) cur_idx = 5'(i);
    end
  end

  assign ack_cur     = |(ack_sync & sel_q);
  assign cnt_expired = (cnt_q == CNT_LAST);
  assign cnt_sat     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and datapath decisions for the sequencing FSM
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    sel_d     = sel_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    err_d     = err_q;
    err_dom_d = err_dom_q;
    aborted_d = aborted_q;

    if (abort_in && (state_q != IDLE) && (state_q != FINISH)) begin
      rem_d     = '0;
      aborted_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rem_d     = bus.mask;
          sel_d     = '0;
          err_d     = 1'b0;
          err_dom_d = '0;
          aborted_d = 1'b0;
          state_d   = SCAN;
        end
      end

      SCAN: begin
        if (aborted_d || (rem_q == '0)) begin
          state_d = FINISH;
        end else begin
          sel_d   = lowest;
          rem_d   = rem_q & ~lowest;
          req_d   = lowest;
          cnt_d   = '0;
          state_d = REQ_HI;
        end
      end

      REQ_HI: begin
        cnt_d = cnt_sat;
        if (ack_cur || cnt_expired) begin
          if (!ack_cur) begin
            err_d = 1'b1;
            if (!err_q) err_dom_d = cur_idx;
          end
          req_d   = '0;
          cnt_d   = '0;
          state_d = ACK_LO;
        end
      end

      ACK_LO: begin
        cnt_d = cnt_sat;
        if (!ack_cur || cnt_expired) begin
          if (ack_cur) begin
            err_d = 1'b1;
            if (!err_q) err_dom_d = cur_idx;
          end
          gap_d = '0;
          if (aborted_d) begin
            state_d = FINISH;
          end else if (GAP_CYCLES == 0) begin
            state_d = SCAN;
          end else begin
            state_d = GAP;
          end
        end
      end

      GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (aborted_d) begin
          state_d = FINISH;
        end else if (gap_q == GAP_END) begin
          state_d = SCAN;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops every request immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      sel_q     <= '0;
      req_q     <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      err_q     <= 1'b0;
      err_dom_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      sel_q     <= sel_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      err_q     <= err_d;
      err_dom_q <= err_dom_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.busy        = (state_q == SCAN) || (state_q == REQ_HI) ||
                           (state_q == ACK_LO) || (state_q == GAP);
  assign bus.done        = (state_q == FINISH);
  assign bus.timeout_err = err_q;
  assign bus.err_domain  = err_dom_q;
  assign bus.rst_req     = req_q;

endmodule

// File: tb/tb_aha_reset_sequencer.sv
// Testbench: tb_aha_reset_sequencer
// Drives the sequencer through directed and randomized scenarios. Reset
// generators are modelled behaviourally: each one echoes its REQ level on ACK
// after a per-domain delay, or is stuck low or stuck high. A monitor logs
// REQ pulses and DONE pulses for comparison against what the mask and the
// generator behaviour imply.
module tb_aha_reset_sequencer;

  localparam int ND     = 8;
  localparam int TO     = 255;
  localparam int GAP    = 4;
  localparam int BUDGET = ND * (2 * TO + GAP + 40) + 100;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  aha_reset_sequencer_if #(.NUM_DOMAINS(ND)) dut_if ();

  aha_reset_sequencer #(
    .NUM_DOMAINS   (ND),
    .TIMEOUT_CYCLES(TO),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  always #5 clk = ~clk;

  // generator model: mode 0 normal echo, 1 stuck low, 2 stuck high
  int mode  [ND];
  int delay [ND];
  bit tgt   [ND];
  int tcnt  [ND];

  // monitor log
  int cyc = 0;
  int rise_dom[$];
  int rise_cyc[$];
  int fall_cyc[$];
  int done_cnt    = 0;
  int done_cyc    = 0;
  int busy_cnt    = 0;
  int overlap_cnt = 0;
  int start_cyc   = 0;
  logic [ND-1:0] prev_req = '0;

  // behavioural reset generators, updated away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < ND; i++) begin
      if (dut_if.rst_req[i] !== tgt[i]) begin
        tgt[i]  = dut_if.rst_req[i];
        tcnt[i] = delay[i];
      end else if (tcnt[i] > 0) begin
        tcnt[i]--;
      end
      case (mode[i])
        1:       dut_if.rst_ack[i] = 1'b0;
        2:       dut_if.rst_ack[i] = 1'b1;
        default: if (tcnt[i] == 0) dut_if.rst_ack[i] = tgt[i];
      endcase
    end
  end

  // monitor of REQ pulses, DONE, BUSY and one-hot violations
  always @(negedge clk) begin
    cyc++;
    if ($countones(dut_if.rst_req) > 1) overlap_cnt++;
    for (int i = 0; i < ND; i++) begin
      if (dut_if.rst_req[i] === 1'b1 && prev_req[i] !== 1'b1) begin
        rise_dom.push_back(i);
        rise_cyc.push_back(cyc);
      end
      if (dut_if.rst_req[i] !== 1'b1 && prev_req[i] === 1'b1) begin
        fall_cyc.push_back(cyc);
      end
    end
    prev_req = dut_if.rst_req;
    if (dut_if.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (dut_if.busy === 1'b1) busy_cnt++;
    if (dut_if.start === 1'b1) start_cyc = cyc;
  end

  task automatic clear_log();
    rise_dom.delete();
    rise_cyc.delete();
    fall_cyc.delete();
    done_cnt    = 0;
    busy_cnt    = 0;
    overlap_cnt = 0;
  endtask

  task automatic set_all_normal(input int d);
    for (int i = 0; i < ND; i++) begin
      mode[i]  = 0;
      delay[i] = d;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [ND-1:0] m);
    @(posedge clk);
    #1;
    dut_if.start = 1'b1;
    dut_if.mask  = m;
    @(posedge clk);
    #1;
    dut_if.start = 1'b0;
  endtask

  // waits at negedges for DONE; returns at the negedge where it is seen
  task automatic wait_done(input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (dut_if.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_done_wait: no DONE within %0d cycles, required DONE", name, BUDGET);
    end
  endtask

  // ascending list of set mask bits, the order handshakes must follow
  function automatic bit order_matches(input logic [ND-1:0] m);
    int exp_q[$];
    for (int i = 0; i < ND; i++) if (m[i]) exp_q.push_back(i);
    if (exp_q.size() != rise_dom.size()) return 1'b0;
    foreach (exp_q[k]) if (exp_q[k] != rise_dom[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    settle(3);
    checks += 5;
    if (dut_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", dut_if.busy); end
    if (dut_if.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b want 0", dut_if.done); end
    if (dut_if.rst_req !== '0) begin failures++; $display("[TB] FAIL reset_req: got %h want 0", dut_if.rst_req); end
    if (dut_if.timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b want 0", dut_if.timeout_err); end
    if (dut_if.err_domain !== 5'd0) begin failures++; $display("[TB] FAIL reset_err_domain: got %0d want 0", dut_if.err_domain); end
    @(negedge clk);
    rst = 1'b0;
    settle(2);
  endtask

  task automatic test_basic();
    bit ok;
    set_all_normal(3);
    settle(4);
    clear_log();
    pulse_start(8'b0000_0101);
    wait_done("basic", ok);
    settle(2);
    checks += 5;
    if (!order_matches(8'b0000_0101)) begin failures++; $display("[TB] FAIL basic_order: got %p want 0,2", rise_dom); end
    if (overlap_cnt != 0) begin failures++; $display("[TB] FAIL basic_overlap: got %0d want 0", overlap_cnt); end
    if (done_cnt != 1) begin failures++; $display("[TB] FAIL basic_done_count: got %0d want 1", done_cnt); end
    if (dut_if.timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL basic_err: got %b want 0", dut_if.timeout_err); end
    if (rise_cyc.size() < 2 || fall_cyc.size() < 1 || (rise_cyc[1] - fall_cyc[0]) < GAP) begin
      failures++;
      $display("[TB] FAIL basic_gap: got rises %p falls %p want >=%0d low cycles", rise_cyc, fall_cyc, GAP);
    end
  endtask

  task automatic test_zero_mask();
    bit ok;
    clear_log();
    pulse_start('0);
    wait_done("zero", ok);
    settle(2);
    checks += 4;
    if (done_cyc - start_cyc != 2) begin failures++; $display("[TB] FAIL zero_latency: got %0d want 2", done_cyc - start_cyc); end
    if (busy_cnt != 1) begin failures++; $display("[TB] FAIL zero_busy_cycles: got %0d want 1", busy_cnt); end
    if (rise_dom.size() != 0) begin failures++; $display("[TB] FAIL zero_req_activity: got %0d pulses want 0", rise_dom.size()); end
    if (done_cnt != 1) begin failures++; $display("[TB] FAIL zero_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_timeout();
    bit ok;
    set_all_normal(2);
    mode[1] = 1;
    settle(4);
    clear_log();
    pulse_start(8'h12);
    wait_done("timeout", ok);
    settle(2);
    checks += 6;
    if (!order_matches(8'h12)) begin failures++; $display("[TB] FAIL timeout_order: got %p want 1,4", rise_dom); end
    if (rise_cyc.size() < 1 || fall_cyc.size() < 1 || (fall_cyc[0] - rise_cyc[0]) != TO) begin
      failures++;
      $display("[TB] FAIL timeout_req_len: got rises %p falls %p want %0d high cycles", rise_cyc, fall_cyc, TO);
    end
    if (dut_if.timeout_err !== 1'b1) begin failures++; $display("[TB] FAIL timeout_err: got %b want 1", dut_if.timeout_err); end
    if (dut_if.err_domain !== 5'd1) begin failures++; $display("[TB] FAIL timeout_err_domain: got %0d want 1", dut_if.err_domain); end
    if (done_cnt != 1) begin failures++; $display("[TB] FAIL timeout_done_count: got %0d want 1", done_cnt); end
    if (overlap_cnt != 0) begin failures++; $display("[TB] FAIL timeout_overlap: got %0d want 0", overlap_cnt); end
    mode[1] = 0;
    settle(4);
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit seen_busy;
    set_all_normal(2);
    settle(4);
    clear_log();
    pulse_start(8'hFF);
    checks++;
    if (dut_if.timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL restart_err_clear: got %b want 0", dut_if.timeout_err); end
    for (int n = 0; n < 200 && rise_dom.size() < 2; n++) @(negedge clk);
    pulse_start(8'h01);
    wait_done("restart", ok);
    // start raised while DONE is high must be ignored
    dut_if.start = 1'b1;
    dut_if.mask  = 8'hFF;
    @(posedge clk);
    #1;
    dut_if.start = 1'b0;
    seen_busy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (dut_if.busy === 1'b1) seen_busy = 1'b1;
    end
    settle(1);
    checks += 4;
    if (!order_matches(8'hFF)) begin failures++; $display("[TB] FAIL restart_order: got %p want 0..7", rise_dom); end
    if (done_cnt != 1) begin failures++; $display("[TB] FAIL restart_done_count: got %0d want 1", done_cnt); end
    if (overlap_cnt != 0) begin failures++; $display("[TB] FAIL restart_overlap: got %0d want 0", overlap_cnt); end
    if (seen_busy) begin failures++; $display("[TB] FAIL finish_start_ignored: got busy=1 want 0"); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    set_all_normal(2);
    mode[3] = 1;
    settle(4);
    clear_log();
    pulse_start(8'h08);
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (dut_if.rst_req[3] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL midreset_req3_seen: got 0 want 1"); end
    #2;
    rst = 1'b1;
    #1;
    checks += 2;
    if (dut_if.rst_req !== '0) begin failures++; $display("[TB] FAIL midreset_req: got %h want 0", dut_if.rst_req); end
    if (dut_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy: got %b want 0", dut_if.busy); end
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    settle(30);
    checks += 2;
    if (done_cnt != 0) begin failures++; $display("[TB] FAIL midreset_no_done: got %0d want 0", done_cnt); end
    if (dut_if.rst_req !== '0) begin failures++; $display("[TB] FAIL midreset_req_after: got %h want 0", dut_if.rst_req); end
    mode[3] = 0;
    settle(4);
  endtask

  task automatic test_random();
    bit ok;
    logic [ND-1:0] m;
    bit exp_err;
    int exp_dom;
    int k;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < ND; i++) begin
        int r;
        r = $urandom_range(0, 11);
        mode[i]  = (r == 0) ? 1 : (r == 1) ? 2 : 0;
        delay[i] = $urandom_range(1, 6);
      end
      m = ND'($urandom_range(0, (1 << ND) - 1));
      settle(6);
      exp_err = 1'b0;
      exp_dom = 0;
      for (int i = 0; i < ND; i++) begin
        if (m[i] && mode[i] != 0 && !exp_err) begin
          exp_err = 1'b1;
          exp_dom = i;
        end
      end
      clear_log();
      pulse_start(m);
      wait_done("random", ok);
      settle(2);
      checks += 5;
      if (!order_matches(m)) begin failures++; $display("[TB] FAIL random_order: mask %h got %p", m, rise_dom); end
      if (dut_if.timeout_err !== exp_err) begin failures++; $display("[TB] FAIL random_err: mask %h got %b want %b", m, dut_if.timeout_err, exp_err); end
      if (dut_if.err_domain !== 5'(exp_dom)) begin failures++; $display("[TB] FAIL random_err_domain: mask %h got %0d want %0d", m, dut_if.err_domain, exp_dom); end
      if (done_cnt != 1) begin failures++; $display("[TB] FAIL random_done_count: got %0d want 1", done_cnt); end
      if (overlap_cnt != 0) begin failures++; $display("[TB] FAIL random_overlap: got %0d want 0", overlap_cnt); end
      k = 0;
      foreach (rise_dom[j]) begin
        if (mode[rise_dom[j]] == 1 && j < fall_cyc.size()) begin
          checks++;
          if (fall_cyc[j] - rise_cyc[j] != TO) begin
            failures++;
            $display("[TB] FAIL random_stuck_len: domain %0d got %0d want %0d", rise_dom[j], fall_cyc[j] - rise_cyc[j], TO);
          end
          k++;
        end
      end
      set_all_normal(2);
      settle(6);
    end
  endtask

`ifdef AHA_RESET_SEQ_ABORT_EN
  task automatic test_abort();
    bit ok;
    set_all_normal(3);
    delay[1] = 5;
    settle(4);
    clear_log();
    pulse_start(8'h0F);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (dut_if.rst_req[1] === 1'b1) break;
    end
    dut_if.abort = 1'b1;
    @(posedge clk);
    #1;
    dut_if.abort = 1'b0;
    wait_done("abort", ok);
    settle(2);
    checks += 4;
    if (!order_matches(8'h03)) begin failures++; $display("[TB] FAIL abort_order: got %p want 0,1", rise_dom); end
    if (fall_cyc.size() != 2) begin failures++; $display("[TB] FAIL abort_req1_completed: got %0d falls want 2", fall_cyc.size()); end
    if (dut_if.timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL abort_err: got %b want 0", dut_if.timeout_err); end
    if (done_cnt != 1) begin failures++; $display("[TB] FAIL abort_done_count: got %0d want 1", done_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    dut_if.start = 1'b0;
    dut_if.mask  = '0;
`ifdef AHA_RESET_SEQ_ABORT_EN
    dut_if.abort = 1'b0;
`endif
    for (int i = 0; i < ND; i++) begin
      tgt[i]  = 1'b0;
      tcnt[i] = 0;
    end
    set_all_normal(2);
    test_reset();
    test_basic();
    test_zero_mask();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef AHA_RESET_SEQ_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
